bitplane_sequencer: RTL
=======================

# bitplane_sequencer

Bit-serial front end of the in-memory-computing MAC datapath, directly upstream of the accumulator stage. It stores a 16-entry signed weight column and accepts 16-lane 4-bit activation vectors over a valid/ready handshake. For each vector it issues four bit-plane partial sums, MSB plane first, on `partialsum`, with the matching `cycle` tag (1, 2, 3, 0) that the accumulator uses to shift-add and to emit its 14-bit result. It also flags the cycle in which that accumulator result is valid.

## Interface
- `N_IN`, 16, number of lanes; only the default is supported (the `partialsum` width is sized for it).
- `WT_BITS`, 6, signed weight width; only the default is supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wt_we`  in  1  weight write strobe.
- `wt_addr`  in  4  weight lane index.
- `wt_data`  in  6  signed weight value.
- `wt_err`  out  1  one-cycle pulse: the write was dropped because the block was busy.
- `in_valid`  in  1  activation vector valid.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_act`  in  64  lane i is at bits [4i+3:4i]; unsigned, or signed when the signed-activation macro is defined.
- `cycle`  out  2  beat tag for the accumulator.
- `partialsum`  out  10  signed bit-plane sum, two's complement.
- `res_valid`  out  1  the accumulator result is valid this cycle.
- `ovf`  out  1  sticky saturation flag; cleared only by reset.

## Operation
- Weight registers are 16 x 6 signed and reset to 0.
  - A write with `wt_we` lands at the next edge, but only while idle (`busy`=0).
  - A write while busy is dropped and `wt_err` pulses for one cycle.
- Internal state:
  - activation register `act`;
  - flag `busy`;
  - plane index `bidx`, 2 bits, pointing at the next plane to issue.
- Handshake:
  - `in_ready` = !`busy` || (`bidx`==0).
  - Transfer occurs when `in_valid` && `in_ready` at a rising edge.
  - On transfer: `act` <= `in_act`, `busy` <= 1, `bidx` <= 3.
- Issue: while `busy`, each edge does the following.
  - It registers `partialsum` = sum over lanes of (act[i][bidx] ? w[i] : 0).
  - It registers `cycle` = {3:1, 2:2, 1:3, 0:0}[bidx].
  - It then decrements `bidx`.
  - After issuing plane 0, `busy` <= 0 unless a new transfer occurs at the same edge.
- Idle: the output registers hold `cycle`=0 and `partialsum`=0.
- `res_valid` is a two-stage delay of "plane 0 issued". It is high in the cycle after the `cycle`=0 beat sat on the outputs, which is when the accumulator result is valid.
- Arithmetic: the lane sum lies in -512..496 and is exact in 10 bits. No saturation is needed in unsigned mode.
- Simultaneous events:
  - If a transfer coincides with the plane-0 issue, the plane-0 beat comes from the old `act` and `act` loads the new vector at the same edge.
  - A `wt_we` at that same edge is dropped, because `busy` was still 1.

## Timing
- A transfer at edge E0 puts beats on the outputs after E1, E2, E3 and E4 with `cycle` = 1, 2, 3, 0. `res_valid` is high between E5 and E6.
- Throughput is one vector per 4 cycles, with no bubbles when `in_valid` is held. Under streaming, `in_ready` is high 1 cycle in 4.
- Reset values: `cycle`=0, `partialsum`=0, `res_valid`=0, `in_ready`=1, `wt_err`=0, `ovf`=0. Also `busy`=0 and all weights are 0.
- Reset mid-vector aborts it immediately, with no remaining beats and no `res_valid`. The downstream accumulator is reset from the same `rst_n` net.

## Configuration
- `BITPLANE_SIGNED_ACT_EN`
  - Defined: activations are two's complement. The plane-3 (MSB) sum is negated before registering, and the negated value is clamped to 511 when it would be 512 (that is, 512 -> 511). Whenever the clamp fires, `ovf` is set and stays set until reset.
  - Undefined: activations are unsigned, no negation is applied, and `ovf` is tied to 0.

## Test plan
- Reset: assert `rst_n`=0 mid-vector -> all outputs take their reset values at once, and after release `in_ready`=1 with no residual beats.
- Unsigned basic: all weights +1, all activations 4'hF -> beats (cycle, psum) = (1,16), (2,16), (3,16), (0,16); `res_valid` one cycle after the last beat; accumulator result = 240.
- Negative weight: lane 0 weight -32 and others 0, lane 0 activation 4'b1010 -> psum -32, 0, -32, 0; result = -320.
- Streaming: two vectors with `in_valid` held high -> 8 contiguous beats with tags 1,2,3,0,1,2,3,0; `in_ready` high only in the plane-0 cycles; two `res_valid` pulses 4 cycles apart.
- Busy write: `wt_we` to lane 3 with value 5 during beat 2 -> `wt_err` pulses, lane 3 weight unchanged, and the following vector uses the old value.
- Signed (macro defined): all weights -32, all activations 4'h8 -> plane-3 beat psum = 511 and `ovf`=1; the other planes are 0.

Source files
------------

// File: rtl/bitplane_sequencer.sv
// Bit-serial weight/activation front end: issues MSB-first bit-plane sums.
// Optional BITPLANE_SIGNED_ACT_EN: two's-complement activations, negated plane 3.
module bitplane_sequencer #(
   parameter int N_IN    = 16,
   parameter int WT_BITS = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wt_we,
   input  logic [3:0]        wt_addr,
   input  logic [5:0]        wt_data,
   output logic              wt_err,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_act,
   output logic [1:0]        cycle,
   output logic signed [9:0] partialsum,
   output logic              res_valid,
   output logic              ovf
);

   logic [WT_BITS-1:0] w [N_IN];
   logic [63:0]        act;
   logic               busy;
   logic [1:0]         bidx;
   logic               xfer;
   logic               p0_d;
   logic signed [9:0]  sum;
   logic signed [9:0]  ps_nxt;
   logic [1:0]         cyc_nxt;
   logic               clamp;

   assign in_ready = !busy || (bidx == 2'd0);
   assign xfer     = in_valid && in_ready;

   // Any subset of lanes sums within -512..496, so 10 bits never wrap
   always_comb begin
      sum = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (act[4*i + int'(bidx)])
            sum = sum + {{(10-WT_BITS){w[i][WT_BITS-1]}}, w[i]};
      end
   end

`ifdef BITPLANE_SIGNED_ACT_EN
   logic signed [10:0] neg;
   always_comb begin
      neg    = -{sum[9], sum};
      ps_nxt = sum;
      clamp  = 1'b0;
      if (bidx == 2'd3) begin
         if (neg == 11'sd512) begin
            ps_nxt = 10'sd511;
            clamp  = 1'b1;
         end else begin
            ps_nxt = neg[9:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (busy && clamp)
         ovf <= 1'b1;
   end
`else
   always_comb begin
      ps_nxt = sum;
      clamp  = 1'b0;
   end
   assign ovf = clamp;
`endif

   always_comb begin
      cyc_nxt = 2'd0;
      unique case (bidx)
         2'd3: cyc_nxt = 2'd1;
         2'd2: cyc_nxt = 2'd2;
         2'd1: cyc_nxt = 2'd3;
         2'd0: cyc_nxt = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++)
            w[i] <= '0;
         wt_err <= 1'b0;
      end else begin
         wt_err <= wt_we && busy;
         if (wt_we && !busy)
            w[wt_addr] <= wt_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act        <= '0;
         busy       <= 1'b0;
         bidx       <= 2'd0;
         cycle      <= 2'd0;
         partialsum <= '0;
         p0_d       <= 1'b0;
         res_valid  <= 1'b0;
      end else begin
         p0_d      <= busy && (bidx == 2'd0);
         res_valid <= p0_d;
         if (busy) begin
            cycle      <= cyc_nxt;
            partialsum <= ps_nxt;
            bidx       <= bidx - 2'd1;
            if (bidx == 2'd0)
               busy <= 1'b0;
         end else begin
            cycle      <= 2'd0;
            partialsum <= '0;
         end
         // A new vector overrides the plane-0 retirement at the same edge
         if (xfer) begin
            act  <= in_act;
            busy <= 1'b1;
            bidx <= 2'd3;
         end
      end
   end

endmodule
